// File: rtl/quadrature_decoder_if.sv
// Quadrature decoder signal bundle: encoder phases and clear in, step/direction/error out.
interface quadrature_decoder_if #(
    parameter int unsigned ErrWidth = 8
);
    logic                phaseA;
    logic                phaseB;
    logic                clrErr;
    logic                step;
    logic                upDown;
    logic                errPulse;
    logic [ErrWidth-1:0] errCount;

    // Encoder/consumer side: drives phases and clear, observes decoder outputs.
    modport master (
        output phaseA, phaseB, clrErr,
        input  step, upDown, errPulse, errCount
    );

    // Decoder side.
    modport slave (
        input  phaseA, phaseB, clrErr,
        output step, upDown, errPulse, errCount
    );
endinterface

// File: rtl/quadrature_decoder.sv
// Quadrature decoder: synchronizes and glitch-filters two encoder phases,
// decodes Gray-code moves into a step pulse plus direction, and flags and
// counts (saturating) illegal double transitions.
module quadrature_decoder #(
    parameter int unsigned FilterLen = 4,
    parameter int unsigned ErrWidth  = 8
) (
    input logic                 clk,
    input logic                 rst,
    quadrature_decoder_if.slave bus
);

    localparam int unsigned CntW    = $clog2(FilterLen + 1);
    localparam int unsigned SettleW = $clog2(FilterLen + 2);

    localparam logic [CntW-1:0]    FiltLast   = CntW'(FilterLen - 1);
    localparam logic [SettleW-1:0] SettleLast = SettleW'(FilterLen + 1);

    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [SettleW-1:0]   settle_q, settle_d;

    // Phase vectors are packed as {A, B}.
    logic [1:0]           sync1_q, sync2_q;
    logic [1:0]           filt_q, filt_d;
    logic [1:0]           prev_q, prev_d;
    logic [1:0][CntW-1:0] fcnt_q, fcnt_d;
    logic [1:0]           chg;

    logic                 step_q, step_d;
    logic                 upDown_q, upDown_d;
    logic                 errPulse_q, errPulse_d;
    logic [ErrWidth-1:0]  errCount_q, errCount_d;

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_RESET;
            settle_q <= '0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
        end
    end

    // FSM next state: RESET -> SETTLE for FilterLen+2 edges -> RUN.
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        unique case (state_q)
            ST_RESET: begin
                state_d  = ST_SETTLE;
                settle_d = '0;
            end
            ST_SETTLE: begin
                if (settle_q == SettleLast) begin
                    state_d = ST_RUN;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RESET;
            end
        endcase
    end

    assign chg = filt_q ^ prev_q;

    // Output/datapath next values: filtering, transition decode, error count.
    always_comb begin
        filt_d     = filt_q;
        prev_d     = prev_q;
        fcnt_d     = fcnt_q;
        step_d     = 1'b0;
        upDown_d   = upDown_q;
        errPulse_d = 1'b0;
        errCount_d = errCount_q;

        if (state_q != ST_RUN) begin
            // Silently track the encoder so RUN starts from its current position.
            filt_d = sync2_q;
            prev_d = filt_q;
            fcnt_d = '0;
        end else begin
            prev_d = filt_q;
            for (int unsigned i = 0; i < 2; i++) begin
                if (sync2_q[i] != filt_q[i]) begin
                    if (fcnt_q[i] == FiltLast) begin
                        filt_d[i] = sync2_q[i];
                        fcnt_d[i] = '0;
                    end else begin
                        fcnt_d[i] = fcnt_q[i] + 1'b1;
                    end
                end else begin
                    fcnt_d[i] = '0;
                end
            end
            unique case (chg)
                2'b01, 2'b10: begin
                    step_d   = 1'b1;
                    // Single-bit Gray move: new A differing from old B means up.
                    upDown_d = filt_q[1] ^ prev_q[0];
                end
                2'b11: begin
                    errPulse_d = 1'b1;
                end
                default: begin
                    step_d = 1'b0;
                end
            endcase
        end

        if (bus.clrErr) begin
            errCount_d = '0;
        end else if (errPulse_d && (errCount_q != '1)) begin
            errCount_d = errCount_q + 1'b1;
        end
    end

    // Datapath registers: synchronizers, filters, previous position, outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            filt_q     <= '0;
            prev_q     <= '0;
            fcnt_q     <= '0;
            step_q     <= 1'b0;
            upDown_q   <= 1'b0;
            errPulse_q <= 1'b0;
            errCount_q <= '0;
        end else begin
            sync1_q    <= {bus.phaseA, bus.phaseB};
            sync2_q    <= sync1_q;
            filt_q     <= filt_d;
            prev_q     <= prev_d;
            fcnt_q     <= fcnt_d;
            step_q     <= step_d;
            upDown_q   <= upDown_d;
            errPulse_q <= errPulse_d;
            errCount_q <= errCount_d;
        end
    end

    assign bus.step     = step_q;
    assign bus.upDown   = upDown_q;
    assign bus.errPulse = errPulse_q;
    assign bus.errCount = errCount_q;

endmodule
